com_mem_arbiter: RTL
====================

# com_mem_arbiter

Round-robin arbiter that shares one port of the 2024 × 32-bit dual-port communication memory among `NUM_REQ` Avalon-MM masters.
- Sits between the requesters (DMA engines, PDO copy logic, host bridge) and the memory port.
- Registers the memory command and routes read data back to the owning requester.
- Supports a per-requester lock so read-modify-write sequences are atomic.
- Drops and flags out-of-range accesses.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `MEM_WORDS`, default 2024: implemented depth. Addresses ≥ `MEM_WORDS` are out of range.
- `ADDR_W`, default 11: word address width.

Ports (vectors flattened per requester, requester i occupies slice i):
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rq_address`  in  `NUM_REQ*ADDR_W`  word address.
- `rq_read`, `rq_write`  in  `NUM_REQ`  transfer request strobes.
- `rq_byteenable`  in  `NUM_REQ*4`  byte lanes.
- `rq_writedata`  in  `NUM_REQ*32`  write data.
- `rq_lock`  in  `NUM_REQ`  keep the grant after this transfer.
- `rq_waitrequest`  out  `NUM_REQ`  high = transfer not accepted.
- `rq_readdata`  out  `NUM_REQ*32`  read data.
- `rq_readdatavalid`  out  `NUM_REQ`  read data strobe.
- `mem_address`  out  `ADDR_W`  to memory port.
- `mem_byteenable`  out  4  to memory port.
- `mem_chipselect`  out  1  to memory port.
- `mem_write`  out  1  to memory port.
- `mem_writedata`  out  32  to memory port.
- `mem_readdata`  in  32  from memory; unregistered output, valid one cycle after the address is clocked.
- `oob_clr`  in  1  clears `oob_err`.
- `oob_err`  out  1  sticky out-of-range flag.

## Operation
- **Request.** Requester i requests when `rq_read[i] | rq_write[i]`. If both are high, the transfer is a write and produces no read data.
- **Arbitration.** Round-robin search starts at `last+1` mod `NUM_REQ`, where `last` is the last accepted requester. `last` resets to `NUM_REQ-1`, so requester 0 wins first.
- **Acceptance.** Exactly one requester is granted per cycle. `rq_waitrequest[i] = ~grant[i]`, so it is high when idle. A transfer is accepted in the cycle its waitrequest is low.
- **Lock.**
  - Accepting a transfer with `rq_lock[i]=1` sets `locked=1`, `owner=i`.
  - While locked, only `owner` can be granted; other requesters see waitrequest high.
  - An accepted `owner` transfer with `rq_lock=0` clears the lock.
  - The lock has no timeout. Deadlock avoidance is the requester's responsibility.
- **Command register.** Accepted address, byteenable and writedata load the `mem_*` registers. `mem_chipselect=1` for one cycle per accepted in-range transfer. `mem_write=1` for writes.
- **Out of range.** Address ≥ `MEM_WORDS`:
  - Transfer is accepted; `mem_chipselect` stays 0.
  - Sets `oob_err`.
  - A read still returns `rq_readdatavalid` with data 0.
- **`oob_err`.** Cleared by `oob_clr`. If `oob_clr` and a new out-of-range event occur in the same cycle, set wins.
- **Read return.** The return pipeline tracks valid, owner and oob per accepted read. `rq_readdata` for the owner is `mem_readdata`, or 0 for out-of-range reads. All non-owner `rq_readdata` slices are 0.

## Timing
- Accept at cycle T → `mem_*` driven in T+1 → `rq_readdatavalid[owner]` and data in T+2. Read latency is fixed at 2 cycles.
- Throughput is one transfer per cycle. Back-to-back reads from different requesters return in acceptance order.
- A write is complete in memory at the end of T+1. A read accepted at T+1 to the same address returns the new data.
- Reset values:
  - All `rq_waitrequest` = 1; all `rq_readdatavalid` = 0; `rq_readdata` = 0.
  - All `mem_*` = 0; `oob_err` = 0; `locked` = 0.
- Reset asserted mid-operation discards in-flight reads. No readdatavalid is produced after reset deasserts.
- The arbiter grant is combinational from registered state plus the request inputs. All other outputs except `rq_readdata` (a combinational mux of `mem_readdata`) are registered.

## Structure
- Package `com_mem_pkg` holds the constants:
  - `COM_MEM_WORDS` = 2024
  - `COM_MEM_ADDR_W` = 11
  - `COM_MEM_DATA_W` = 32
  - `COM_MEM_BE_W` = 4
  - `COM_MEM_RD_LAT` = 2
- Sub-module `com_mem_rr_arb` contains the round-robin grant, the `last` pointer and the lock/owner state. The top level holds the command register, the return pipeline and the oob logic.

## Test plan
- **Reset.** Hold `reset_n`=0 with all requesters requesting → waitrequest all 1, `mem_chipselect`=0. Release → requester 0 is accepted first.
- **Contention.** Requesters 0 and 1 continuously read addresses 0x010 and 0x020 → grants alternate 0,1,0,1; each readdatavalid lands 2 cycles after its accept with the correct owner and data.
- **Lock.** Requester 1 reads 0x005 with lock=1, then writes 0x005 = 0xA5A5_0001 with lock=0; requester 0 requests throughout → requester 0 is not granted until the cycle after requester 1's write is accepted.
- **Byte-lane write.** Write 0x7E7 = 0xFFFF_FFFF, then write 0x12345678 with byteenable=0b0101, then read → 0xFF34FF78.
- **Out of range.** Write to 0x7E8 (2024), then read it → `mem_chipselect` stays 0, `oob_err`=1, read returns 0 with valid. `oob_clr` asserted in the same cycle as a second out-of-range event → `oob_err` remains 1.
- **Reset mid-read.** Accept a read, assert `reset_n`=0 at T+1 → no readdatavalid at T+2 or afterward.

Source files
------------

// File: rtl/com_mem_pkg.sv
// Shared constants for the communication-memory arbiter slice.
package com_mem_pkg;

    localparam int COM_MEM_WORDS  = 2024;
    localparam int COM_MEM_ADDR_W = 11;
    localparam int COM_MEM_DATA_W = 32;
    localparam int COM_MEM_BE_W   = 4;
    localparam int COM_MEM_RD_LAT = 2;

endpackage

// File: rtl/com_mem_rr_arb.sv
// Round-robin grant with per-requester lock. The grant is combinational from
// the registered pointer/lock state and the live request vector.
module com_mem_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] last_reg;
    logic             locked_reg;
    logic [IDX_W-1:0] owner_reg;

    // Pick the requester: the lock owner only while locked, otherwise the first
    // requester found searching upward from last+1 with wrap-around.
    // Grant is forced off while reset is held so every waitrequest reads high.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (reset_n) begin
            if (locked_reg) begin
                if (req[owner_reg]) begin
                    grant_valid = 1'b1;
                    grant_idx   = owner_reg;
                end
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = int'(last_reg) + k;
                    if (cand >= NUM_REQ) begin
                        cand = cand - NUM_REQ;
                    end
                    cand_idx = IDX_W'(cand);
                    if (!grant_valid && req[cand_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = cand_idx;
                    end
                end
            end
            if (grant_valid) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    // Remember the accepted requester; its lock bit decides whether the grant
    // is pinned to it (a locked owner dropping lock releases the pin).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg   <= IDX_W'(NUM_REQ - 1);
            locked_reg <= 1'b0;
            owner_reg  <= '0;
        end else if (grant_valid) begin
            last_reg   <= grant_idx;
            locked_reg <= lock[grant_idx];
            owner_reg  <= grant_idx;
        end
    end

endmodule

// File: rtl/com_mem_arbiter.sv
// Shares one port of the communication memory among NUM_REQ Avalon-MM masters:
// registered memory command, fixed two-cycle read return, out-of-range trap.
module com_mem_arbiter
    import com_mem_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MEM_WORDS = COM_MEM_WORDS,
    parameter int ADDR_W    = COM_MEM_ADDR_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]          rq_address,
    input  logic [NUM_REQ-1:0]                 rq_read,
    input  logic [NUM_REQ-1:0]                 rq_write,
    input  logic [NUM_REQ*COM_MEM_BE_W-1:0]    rq_byteenable,
    input  logic [NUM_REQ*COM_MEM_DATA_W-1:0]  rq_writedata,
    input  logic [NUM_REQ-1:0]                 rq_lock,
    output logic [NUM_REQ-1:0]                 rq_waitrequest,
    output logic [NUM_REQ*COM_MEM_DATA_W-1:0]  rq_readdata,
    output logic [NUM_REQ-1:0]                 rq_readdatavalid,
    output logic [ADDR_W-1:0]                  mem_address,
    output logic [COM_MEM_BE_W-1:0]            mem_byteenable,
    output logic                               mem_chipselect,
    output logic                               mem_write,
    output logic [COM_MEM_DATA_W-1:0]          mem_writedata,
    input  logic [COM_MEM_DATA_W-1:0]          mem_readdata,
    input  logic                               oob_clr,
    output logic                               oob_err
);

    localparam int DW    = COM_MEM_DATA_W;
    localparam int BW    = COM_MEM_BE_W;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;

    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [BW-1:0]      be_a   [NUM_REQ];
    logic [DW-1:0]      wd_a   [NUM_REQ];

    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_write;
    logic               sel_oob;

    logic [ADDR_W-1:0]  mem_address_reg;
    logic [BW-1:0]      mem_byteenable_reg;
    logic               mem_chipselect_reg;
    logic               mem_write_reg;
    logic [DW-1:0]      mem_writedata_reg;

    logic               rd_v1_reg;
    logic [IDX_W-1:0]   rd_owner1_reg;
    logic               rd_oob1_reg;
    logic [NUM_REQ-1:0] rdv_reg;
    logic               rd_oob2_reg;
    logic               oob_err_reg;

    // Unflatten per-requester slices and return read data to the owner only.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_a[gi] = rq_address[gi*ADDR_W +: ADDR_W];
        assign be_a[gi]   = rq_byteenable[gi*BW +: BW];
        assign wd_a[gi]   = rq_writedata[gi*DW +: DW];
        assign rq_readdata[gi*DW +: DW] = (rdv_reg[gi] && !rd_oob2_reg) ? mem_readdata : '0;
    end

    assign req = rq_read | rq_write;

    com_mem_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (rq_lock),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign rq_waitrequest = ~grant;

    // A write strobe dominates, so read|write together is treated as a write.
    assign sel_addr  = addr_a[grant_idx];
    assign sel_write = rq_write[grant_idx];
    assign sel_oob   = (32'(sel_addr) >= 32'(MEM_WORDS));

    // Memory command register: chipselect pulses once per accepted in-range transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address_reg    <= '0;
            mem_byteenable_reg <= '0;
            mem_chipselect_reg <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_writedata_reg  <= '0;
        end else begin
            mem_chipselect_reg <= grant_valid & ~sel_oob;
            mem_write_reg      <= grant_valid & ~sel_oob & sel_write;
            if (grant_valid) begin
                mem_address_reg    <= sel_addr;
                mem_byteenable_reg <= be_a[grant_idx];
                mem_writedata_reg  <= wd_a[grant_idx];
            end
        end
    end

    // Read return pipeline: stage 1 lines up with the memory command, stage 2
    // with the memory's data, so data is valid exactly two cycles after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1_reg     <= 1'b0;
            rd_owner1_reg <= '0;
            rd_oob1_reg   <= 1'b0;
            rdv_reg       <= '0;
            rd_oob2_reg   <= 1'b0;
        end else begin
            rd_v1_reg     <= grant_valid & ~sel_write;
            rd_owner1_reg <= grant_idx;
            rd_oob1_reg   <= sel_oob;
            rdv_reg       <= rd_v1_reg ? (NUM_REQ'(1) << rd_owner1_reg) : '0;
            rd_oob2_reg   <= rd_oob1_reg;
        end
    end

    // Sticky out-of-range flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_err_reg <= 1'b0;
        end else if (grant_valid && sel_oob) begin
            oob_err_reg <= 1'b1;
        end else if (oob_clr) begin
            oob_err_reg <= 1'b0;
        end
    end

    assign mem_address      = mem_address_reg;
    assign mem_byteenable   = mem_byteenable_reg;
    assign mem_chipselect   = mem_chipselect_reg;
    assign mem_write        = mem_write_reg;
    assign mem_writedata    = mem_writedata_reg;
    assign rq_readdatavalid = rdv_reg;
    assign oob_err          = oob_err_reg;

endmodule
